// File: rtl/uart_top_unit.sv
// -----------------------------------------------------------------------------
// uart_top_unit -- full-duplex 8N1 UART with 16x oversampling tick generator,
// a receiver and a transmitter, each fronted by a circular FIFO.
//
// Frame: start bit (0), NB_DATA data bits LSB first, one stop bit (1).
// The idle line is 1.
//
// Optional feature macro: UART_ERR_FLAGS_EN
//   When defined, adds sticky outputs o_rx_ferr (framing error) and
//   o_rx_ovr (RX FIFO overrun). Both are cleared only by reset.
//
// Ports
//   clk         system clock
//   i_rst       asynchronous active-high reset
//   i_tick_cmp  clocks per oversampling tick (0 behaves as 1)
//   i_rx        serial input (asynchronous, synchronised internally)
//   o_tx        serial output (forced to 1 while in reset)
//   i_wdata     byte to transmit / byte to push into the TX FIFO
//   i_wr        push i_wdata into the TX FIFO
//   i_tx_start  start the transmitter when it is idle
//   o_tx_done   one-clock pulse at the end of each stop bit sent
//   o_tx_empty  TX FIFO empty
//   o_tx_full   TX FIFO full
//   o_rdata     RX FIFO head (first-word fall-through), 0 when empty
//   i_rd        pop the RX FIFO
//   o_rx_done   one-clock pulse when a received byte with valid stop bit ends
//   o_rx_empty  RX FIFO empty
//   o_rx_full   RX FIFO full
//   o_rx_ferr   (UART_ERR_FLAGS_EN) sticky framing error
//   o_rx_ovr    (UART_ERR_FLAGS_EN) sticky overrun
// -----------------------------------------------------------------------------
module uart_top_unit #(
    parameter int NB_COUNTER   = 9,
    parameter int NB_DATA      = 8,
    parameter int NB_FIFO_ADDR = 4
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic [NB_COUNTER-1:0] i_tick_cmp,
    input  logic                  i_rx,
    output logic                  o_tx,
    input  logic [NB_DATA-1:0]    i_wdata,
    input  logic                  i_wr,
    input  logic                  i_tx_start,
    output logic                  o_tx_done,
    output logic                  o_tx_empty,
    output logic                  o_tx_full,
    output logic [NB_DATA-1:0]    o_rdata,
    input  logic                  i_rd,
    output logic                  o_rx_done,
    output logic                  o_rx_empty,
`ifdef UART_ERR_FLAGS_EN
    output logic                  o_rx_ferr,
    output logic                  o_rx_ovr,
`endif
    output logic                  o_rx_full
);

    localparam int NB_BIT = $clog2(NB_DATA);
    localparam int DEPTH  = 2**NB_FIFO_ADDR;
    localparam logic [NB_FIFO_ADDR:0]   CNT_FULL = (NB_FIFO_ADDR+1)'(DEPTH);
    localparam logic [NB_FIFO_ADDR:0]   CNT_ONE  = (NB_FIFO_ADDR+1)'(1);
    localparam logic [NB_FIFO_ADDR-1:0] PTR_ONE  = NB_FIFO_ADDR'(1);
    localparam logic [NB_BIT-1:0]       BIT_LAST = NB_BIT'(NB_DATA-1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // ---------------- oversampling tick ----------------
    logic [NB_COUNTER-1:0] tick_cnt;
    logic [NB_COUNTER-1:0] tick_last;
    logic                  tick;

    // A compare value of 0 collapses to a tick every clock, same as 1.
    assign tick_last = (i_tick_cmp == '0) ? '0 : i_tick_cmp - NB_COUNTER'(1);
    assign tick      = (tick_cnt == tick_last);

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) tick_cnt <= '0;
        else       tick_cnt <= tick ? '0 : tick_cnt + NB_COUNTER'(1);
    end

    // ---------------- TX FIFO ----------------
    logic [NB_DATA-1:0]      tx_mem [DEPTH];
    logic [NB_FIFO_ADDR-1:0] tx_wptr, tx_rptr;
    logic [NB_FIFO_ADDR:0]   tx_cnt;
    logic                    tx_push, tx_pop;
    logic [NB_DATA-1:0]      tx_head;

    assign o_tx_empty = (tx_cnt == '0);
    assign o_tx_full  = (tx_cnt == CNT_FULL);
    assign tx_head    = tx_mem[tx_rptr];
    // A write into a full FIFO is accepted only when a pop frees a slot that clock.
    assign tx_push    = i_wr && (!o_tx_full || tx_pop);

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            tx_wptr <= '0;
            tx_rptr <= '0;
            tx_cnt  <= '0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + PTR_ONE;
            if (tx_pop)  tx_rptr <= tx_rptr + PTR_ONE;
            if (tx_push && !tx_pop)      tx_cnt <= tx_cnt + CNT_ONE;
            else if (tx_pop && !tx_push) tx_cnt <= tx_cnt - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wptr] <= i_wdata;
    end

    // ---------------- transmitter ----------------
    logic [1:0]         tx_state;
    logic [3:0]         tx_tcnt;
    logic [NB_BIT-1:0]  tx_bcnt;
    logic [NB_DATA-1:0] tx_shreg;
    logic               tx_line;
    logic               tx_bit_end;

    assign tx_bit_end = tick && (tx_tcnt == 4'd15);
    assign tx_pop     = !o_tx_empty &&
                        (((tx_state == ST_IDLE) && i_tx_start) ||
                         ((tx_state == ST_STOP) && tx_bit_end));
    assign o_tx       = tx_line;

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            tx_state  <= ST_IDLE;
            tx_tcnt   <= '0;
            tx_bcnt   <= '0;
            tx_line   <= 1'b1;
            o_tx_done <= 1'b0;
        end else begin
            o_tx_done <= 1'b0;
            // 4-bit tick counter wraps to 0 at each bit boundary by itself.
            if (tick && (tx_state != ST_IDLE)) tx_tcnt <= tx_tcnt + 4'd1;
            case (tx_state)
                ST_IDLE: begin
                    if (i_tx_start) begin
                        tx_state <= ST_START;
                        tx_tcnt  <= '0;
                    end
                end
                ST_START: begin
                    if (tx_bit_end) begin
                        tx_state <= ST_DATA;
                        tx_bcnt  <= '0;
                    end
                end
                ST_DATA: begin
                    if (tx_bit_end) begin
                        tx_bcnt <= tx_bcnt + NB_BIT'(1);
                        if (tx_bcnt == BIT_LAST) tx_state <= ST_STOP;
                    end
                end
                default: begin
                    if (tx_bit_end) begin
                        o_tx_done <= 1'b1;
                        tx_state  <= o_tx_empty ? ST_IDLE : ST_START;
                    end
                end
            endcase
            // Registered line level keeps o_tx glitch-free.
            tx_line <= (tx_state == ST_START) ? 1'b0 :
                       (tx_state == ST_DATA)  ? tx_shreg[0] : 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if ((tx_state == ST_IDLE) && i_tx_start)
            tx_shreg <= o_tx_empty ? i_wdata : tx_head;
        else if ((tx_state == ST_DATA) && tx_bit_end)
            tx_shreg <= tx_shreg >> 1;
        else if ((tx_state == ST_STOP) && tx_bit_end && !o_tx_empty)
            tx_shreg <= tx_head;
    end

    // ---------------- receiver ----------------
    logic               rx_s1, rx_s2, rx_prev;
    logic [1:0]         rx_state;
    logic [3:0]         rx_tcnt;
    logic [NB_BIT-1:0]  rx_bcnt;
    logic [NB_DATA-1:0] rx_shreg;
    logic               rx_bit_end, rx_mid;
    logic               rx_stop_ok, rx_stop_bad, rx_push, rx_pop, rx_drop;

    assign rx_bit_end  = tick && (rx_tcnt == 4'd15);
    assign rx_mid      = tick && (rx_tcnt == 4'd7);
    assign rx_stop_ok  = (rx_state == ST_STOP) && rx_bit_end && rx_s2;
    assign rx_stop_bad = (rx_state == ST_STOP) && rx_bit_end && !rx_s2;
    assign rx_pop      = i_rd && !o_rx_empty;
    assign rx_push     = rx_stop_ok && (!o_rx_full || rx_pop);
    assign rx_drop     = rx_stop_ok && o_rx_full && !rx_pop;

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            rx_s1     <= 1'b1;
            rx_s2     <= 1'b1;
            rx_prev   <= 1'b1;
            rx_state  <= ST_IDLE;
            rx_tcnt   <= '0;
            rx_bcnt   <= '0;
            o_rx_done <= 1'b0;
        end else begin
            rx_s1     <= i_rx;
            rx_s2     <= rx_s1;
            rx_prev   <= rx_s2;
            // Done pulses even on overrun; only a bad stop bit suppresses it.
            o_rx_done <= rx_stop_ok;
            if (tick && (rx_state != ST_IDLE)) rx_tcnt <= rx_tcnt + 4'd1;
            case (rx_state)
                ST_IDLE: begin
                    if (rx_prev && !rx_s2) begin
                        rx_state <= ST_START;
                        rx_tcnt  <= '0;
                    end
                end
                ST_START: begin
                    // Mid start bit: a high line means the edge was a glitch.
                    if (rx_mid) begin
                        rx_state <= rx_s2 ? ST_IDLE : ST_DATA;
                        rx_tcnt  <= '0;
                        rx_bcnt  <= '0;
                    end
                end
                ST_DATA: begin
                    if (rx_bit_end) begin
                        rx_bcnt <= rx_bcnt + NB_BIT'(1);
                        if (rx_bcnt == BIT_LAST) rx_state <= ST_STOP;
                    end
                end
                default: begin
                    // Leave at stop-bit centre so the next start edge is seen.
                    if (rx_bit_end) rx_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if ((rx_state == ST_DATA) && rx_bit_end)
            rx_shreg <= {rx_s2, rx_shreg[NB_DATA-1:1]};
    end

    // ---------------- RX FIFO ----------------
    logic [NB_DATA-1:0]      rx_mem [DEPTH];
    logic [NB_FIFO_ADDR-1:0] rx_wptr, rx_rptr;
    logic [NB_FIFO_ADDR:0]   rx_cnt;

    assign o_rx_empty = (rx_cnt == '0);
    assign o_rx_full  = (rx_cnt == CNT_FULL);
    assign o_rdata    = o_rx_empty ? '0 : rx_mem[rx_rptr];

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            rx_wptr <= '0;
            rx_rptr <= '0;
            rx_cnt  <= '0;
        end else begin
            if (rx_push) rx_wptr <= rx_wptr + PTR_ONE;
            if (rx_pop)  rx_rptr <= rx_rptr + PTR_ONE;
            if (rx_push && !rx_pop)      rx_cnt <= rx_cnt + CNT_ONE;
            else if (rx_pop && !rx_push) rx_cnt <= rx_cnt - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wptr] <= rx_shreg;
    end

`ifdef UART_ERR_FLAGS_EN
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            o_rx_ferr <= 1'b0;
            o_rx_ovr  <= 1'b0;
        end else begin
            if (rx_stop_bad) o_rx_ferr <= 1'b1;
            if (rx_drop)     o_rx_ovr  <= 1'b1;
        end
    end
`else
    logic unused_err;
    assign unused_err = rx_stop_bad ^ rx_drop;
`endif

endmodule

// File: tb/tb_uart_top_unit.sv
// Loopback bench: instance A transmits into instance B. B's serial input can
// be switched to a bench-driven line for malformed frames.
module tb_uart_top_unit;

    localparam int BIT_CLKS = 32;   // tick_cmp = 2 -> 2 clks/tick, 16 ticks/bit

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [8:0] tick_cmp = 9'd2;

    logic       a_tx, a_tx_done, a_tx_empty, a_tx_full, a_rx_done, a_rx_empty, a_rx_full;
    logic [7:0] a_wdata = 8'h00, a_rdata;
    logic       a_wr = 1'b0, a_start = 1'b0;

    logic       b_tx, b_tx_done, b_tx_empty, b_tx_full, b_rx_done, b_rx_empty, b_rx_full;
    logic [7:0] b_rdata;
    logic       b_rd = 1'b0;

    logic       b_sel = 1'b0, tb_rx = 1'b1, b_rx_in;
    assign b_rx_in = b_sel ? tb_rx : a_tx;

`ifdef UART_ERR_FLAGS_EN
    logic a_ferr, a_ovr, b_ferr, b_ovr;
`endif

    always #5 clk = ~clk;

    uart_top_unit u_a (
        .clk(clk), .i_rst(rst), .i_tick_cmp(tick_cmp), .i_rx(b_tx), .o_tx(a_tx),
        .i_wdata(a_wdata), .i_wr(a_wr), .i_tx_start(a_start), .o_tx_done(a_tx_done),
        .o_tx_empty(a_tx_empty), .o_tx_full(a_tx_full), .o_rdata(a_rdata), .i_rd(1'b0),
        .o_rx_done(a_rx_done), .o_rx_empty(a_rx_empty),
`ifdef UART_ERR_FLAGS_EN
        .o_rx_ferr(a_ferr), .o_rx_ovr(a_ovr),
`endif
        .o_rx_full(a_rx_full)
    );

    uart_top_unit u_b (
        .clk(clk), .i_rst(rst), .i_tick_cmp(tick_cmp), .i_rx(b_rx_in), .o_tx(b_tx),
        .i_wdata(8'h00), .i_wr(1'b0), .i_tx_start(1'b0), .o_tx_done(b_tx_done),
        .o_tx_empty(b_tx_empty), .o_tx_full(b_tx_full), .o_rdata(b_rdata), .i_rd(b_rd),
        .o_rx_done(b_rx_done), .o_rx_empty(b_rx_empty),
`ifdef UART_ERR_FLAGS_EN
        .o_rx_ferr(b_ferr), .o_rx_ovr(b_ovr),
`endif
        .o_rx_full(b_rx_full)
    );

    // Pulse counters and the RX head captured in the o_rx_done cycle.
    int         a_done_cnt = 0;
    int         b_done_cnt = 0;
    logic [7:0] b_last = 8'h00;
    always @(negedge clk) begin
        if (a_tx_done) a_done_cnt <= a_done_cnt + 1;
        if (b_rx_done) begin
            b_done_cnt <= b_done_cnt + 1;
            b_last     <= b_rdata;
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_rx(input int target, input int budget, input string name);
        int k = 0;
        while (b_done_cnt < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, b_done_cnt, target);
    endtask

    task automatic wait_line_low(input string name);
        int k = 0;
        while (a_tx !== 1'b0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check(name, int'(a_tx), 0);
    endtask

    task automatic send_a(input logic [7:0] d);
        @(negedge clk);
        a_wdata = d;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
    endtask

    task automatic write_a(input logic [7:0] d);
        @(negedge clk);
        a_wdata = d;
        a_wr    = 1'b1;
        @(negedge clk);
        a_wr    = 1'b0;
    endtask

    task automatic pop_b();
        @(negedge clk);
        b_rd = 1'b1;
        @(negedge clk);
        b_rd = 1'b0;
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic stop);
        @(negedge clk);
        tb_rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            tb_rx = d[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        tb_rx = stop;
        repeat (BIT_CLKS) @(negedge clk);
        tb_rx = 1'b1;
    endtask

    typedef struct {
        logic [7:0] wdata;
        logic [7:0] fifo_byte;
        logic       via_fifo;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         base_a, base_b, k;
        logic [7:0] d;

        vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00};
        vecs[1] = '{8'hFF, 8'h00, 1'b0, 8'hFF};
        vecs[2] = '{8'h80, 8'h00, 1'b0, 8'h80};
        vecs[3] = '{8'hEE, 8'h3A, 1'b1, 8'h3A};
        vecs[4] = '{8'h11, 8'hC6, 1'b1, 8'hC6};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx_line", int'(a_tx), 1);
        check("rst_tx_empty", int'(a_tx_empty), 1);
        check("rst_tx_full", int'(a_tx_full), 0);
        check("rst_rx_empty", int'(b_rx_empty), 1);
        check("rst_rx_full", int'(b_rx_full), 0);
        check("rst_rdata", int'(b_rdata), 0);
        check("rst_tx_done", int'(a_tx_done), 0);
        check("rst_rx_done", int'(b_rx_done), 0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("idle_tx_line", int'(a_tx), 1);
        check("idle_no_pulses", a_done_cnt + b_done_cnt, 0);
`ifdef UART_ERR_FLAGS_EN
        check("rst_ferr", int'(b_ferr), 0);
        check("rst_ovr", int'(b_ovr), 0);
`endif

        // Single frame 0x01 from i_wdata, serial bits checked at bit centres
        base_a = a_done_cnt;
        base_b = b_done_cnt;
        d = 8'h01;
        send_a(d);
        wait_line_low("t1_start_edge");
        repeat (BIT_CLKS/2) @(negedge clk);
        check("t1_start_bit", int'(a_tx), 0);
        for (int i = 0; i < 8; i++) begin
            repeat (BIT_CLKS) @(negedge clk);
            check($sformatf("t1_data_bit%0d", i), int'(a_tx), int'(d[i]));
        end
        repeat (BIT_CLKS) @(negedge clk);
        check("t1_stop_bit", int'(a_tx), 1);
        wait_rx(base_b + 1, 100, "t1_rx_done");
        check("t1_rdata_at_done", int'(b_last), 8'h01);
        check("t1_rx_empty", int'(b_rx_empty), 0);
        repeat (40) @(negedge clk);
        check("t1_tx_done_cnt", a_done_cnt, base_a + 1);
        pop_b();
        check("t1_rx_empty_after_pop", int'(b_rx_empty), 1);
        check("t1_rdata_after_pop", int'(b_rdata), 0);

        // Table: direct i_wdata frames and FIFO-head frames
        for (int r = 0; r < 5; r++) begin
            base_a = a_done_cnt;
            base_b = b_done_cnt;
            if (vecs[r].via_fifo) begin
                write_a(vecs[r].fifo_byte);
                check($sformatf("v%0d_tx_not_empty", r), int'(a_tx_empty), 0);
            end
            send_a(vecs[r].wdata);
            wait_rx(base_b + 1, 500, $sformatf("v%0d_rx_done", r));
            check($sformatf("v%0d_rdata", r), int'(b_last), int'(vecs[r].exp));
            check($sformatf("v%0d_rx_empty", r), int'(b_rx_empty), 0);
            repeat (40) @(negedge clk);
            check($sformatf("v%0d_tx_done_cnt", r), a_done_cnt, base_a + 1);
            check($sformatf("v%0d_tx_empty", r), int'(a_tx_empty), 1);
            pop_b();
            check($sformatf("v%0d_rx_empty_pop", r), int'(b_rx_empty), 1);
        end

        // Back-to-back frames from the TX FIFO
        base_a = a_done_cnt;
        base_b = b_done_cnt;
        write_a(8'hA5);
        write_a(8'h5A);
        write_a(8'hFF);
        check("b2b_tx_not_empty", int'(a_tx_empty), 0);
        send_a(8'h00);
        wait_rx(base_b + 3, 1300, "b2b_rx_done3");
        repeat (40) @(negedge clk);
        check("b2b_tx_done_cnt", a_done_cnt, base_a + 3);
        check("b2b_tx_empty", int'(a_tx_empty), 1);
        check("b2b_pop0", int'(b_rdata), 8'hA5);
        pop_b();
        check("b2b_pop1", int'(b_rdata), 8'h5A);
        pop_b();
        check("b2b_pop2", int'(b_rdata), 8'hFF);
        pop_b();
        check("b2b_rx_empty", int'(b_rx_empty), 1);

        // 17 bytes into a 16-deep RX FIFO; write-when-full on TX side ignored
        base_b = b_done_cnt;
        for (int i = 0; i < 16; i++) write_a(8'(i));
        check("ovf_tx_full", int'(a_tx_full), 1);
        write_a(8'hEE);
        check("ovf_tx_full_hold", int'(a_tx_full), 1);
        send_a(8'h00);
        k = 0;
        while (a_tx_full && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("ovf_tx_slot_freed", int'(a_tx_full), 0);
        write_a(8'h10);
        wait_rx(base_b + 16, 6000, "ovf_rx_done16");
        check("ovf_rx_full", int'(b_rx_full), 1);
        wait_rx(base_b + 17, 500, "ovf_rx_done17");
`ifdef UART_ERR_FLAGS_EN
        check("ovf_flag", int'(b_ovr), 1);
`endif
        for (int i = 0; i < 16; i++) begin
            check($sformatf("ovf_pop%0d", i), int'(b_rdata), i);
            pop_b();
        end
        check("ovf_rx_empty", int'(b_rx_empty), 1);
        check("ovf_rx_not_full", int'(b_rx_full), 0);

        // Framing error, start glitch, then a good bench-driven frame
        @(negedge clk);
        b_sel = 1'b1;
        base_b = b_done_cnt;
        drive_frame(8'h55, 1'b0);
        repeat (64) @(negedge clk);
        check("ferr_no_done", b_done_cnt, base_b);
        check("ferr_rx_empty", int'(b_rx_empty), 1);
`ifdef UART_ERR_FLAGS_EN
        check("ferr_flag", int'(b_ferr), 1);
`endif
        tb_rx = 1'b0;
        repeat (6) @(negedge clk);
        tb_rx = 1'b1;
        repeat (100) @(negedge clk);
        check("glitch_no_done", b_done_cnt, base_b);
        drive_frame(8'h96, 1'b1);
        wait_rx(base_b + 1, 100, "drv_rx_done");
        check("drv_rdata", int'(b_last), 8'h96);
        check("drv_rx_empty", int'(b_rx_empty), 0);
        @(negedge clk);
        b_sel = 1'b0;
        repeat (40) @(negedge clk);

        // Reset in the middle of frame 0xC3 (bit 2 is 0)
        send_a(8'hC3);
        wait_line_low("rst_frame_start");
        write_a(8'h77);
        check("rst_pre_tx_not_empty", int'(a_tx_empty), 0);
        repeat (BIT_CLKS/2 + 3*BIT_CLKS - 2) @(negedge clk);
        check("rst_pre_line_low", int'(a_tx), 0);
        #2 rst = 1'b1;
        #1 check("rst_async_tx_high", int'(a_tx), 1);
        repeat (3) @(negedge clk);
        check("rst_mid_tx_empty", int'(a_tx_empty), 1);
        check("rst_mid_rx_empty", int'(b_rx_empty), 1);
        check("rst_mid_rdata", int'(b_rdata), 0);
        check("rst_mid_line", int'(a_tx), 1);
`ifdef UART_ERR_FLAGS_EN
        check("rst_mid_ferr_clr", int'(b_ferr), 0);
        check("rst_mid_ovr_clr", int'(b_ovr), 0);
`endif
        rst = 1'b0;
        repeat (40) @(negedge clk);
        base_a = a_done_cnt;
        base_b = b_done_cnt;
        send_a(8'h3C);
        wait_rx(base_b + 1, 500, "post_rst_rx_done");
        check("post_rst_rdata", int'(b_last), 8'h3C);
        repeat (40) @(negedge clk);
        check("post_rst_tx_done", a_done_cnt, base_a + 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
